// File: rtl/conv_ctrl_pkg.sv
// Shared types and index-width helpers for the convolution loop controller.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Unsigned index width for a loop of n iterations (at least 1 bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Signed coordinate width for a map dimension of n pixels.
  function automatic int unsigned coord_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Loop counter: advances on inc, returns to zero after max, flags wrap in the same cycle.
module wrap_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = (count_q == max) ? '0 : count_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
  assign wrap  = inc && (count_q == max);

endmodule

// File: rtl/conv_loop_ctrl.sv
// Convolution loop sequencer: walks oy/ox/och-group/ky/kx/ich, emits step indices
// with padding detection, and hands each finished group to the output side.
module conv_loop_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned FEATURE_MAP_WIDTH  = 64,
  parameter int unsigned FEATURE_MAP_HEIGHT = 64,
  parameter int unsigned INPUT_NB_CHANNELS  = 4,
  parameter int unsigned OUTPUT_NB_CHANNELS = 32,
  parameter int unsigned KERNEL_SIZE        = 3,
  parameter int unsigned OC_PARALLEL        = 4,
  localparam int unsigned ICW = idx_w(INPUT_NB_CHANNELS),
  localparam int unsigned KW  = idx_w(KERNEL_SIZE),
  localparam int unsigned OBW = idx_w(OUTPUT_NB_CHANNELS),
  localparam int unsigned XW  = idx_w(FEATURE_MAP_WIDTH),
  localparam int unsigned YW  = idx_w(FEATURE_MAP_HEIGHT),
  localparam int unsigned CXW = coord_w(FEATURE_MAP_WIDTH),
  localparam int unsigned CYW = coord_w(FEATURE_MAP_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  input  logic                  cfg_same_pad,
  input  logic                  cfg_stride2,
  input  logic                  con_valid,
  output logic                  con_ready,
  output logic                  step_fire,
  output logic signed [CXW-1:0] in_x,
  output logic signed [CYW-1:0] in_y,
  output logic [ICW-1:0]        ich,
  output logic [KW-1:0]         kx,
  output logic [KW-1:0]         ky,
  output logic [OBW-1:0]        och_base,
  output logic                  pad_zero,
  output logic                  acc_first,
  output logic                  acc_last,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [XW-1:0]         output_x,
  output logic [YW-1:0]         output_y,
  output logic [OBW-1:0]        output_ch,
  output logic                  running,
  output logic                  done
);

  localparam int unsigned W  = FEATURE_MAP_WIDTH;
  localparam int unsigned H  = FEATURE_MAP_HEIGHT;
  localparam int unsigned K  = KERNEL_SIZE;
  localparam int unsigned NG = OUTPUT_NB_CHANNELS / OC_PARALLEL;
  localparam int unsigned GW = idx_w(NG);
  localparam int unsigned XI = XW + KW + 3;
  localparam int unsigned YI = YW + KW + 3;

  // Last output column/row index for each padding/stride combination.
  localparam logic [XW-1:0] OXM_V1 = XW'(W - K);
  localparam logic [XW-1:0] OXM_V2 = XW'((W - K) / 2);
  localparam logic [XW-1:0] OXM_S1 = XW'(W - 1);
  localparam logic [XW-1:0] OXM_S2 = XW'((W + 1) / 2 - 1);
  localparam logic [YW-1:0] OYM_V1 = YW'(H - K);
  localparam logic [YW-1:0] OYM_V2 = YW'((H - K) / 2);
  localparam logic [YW-1:0] OYM_S1 = YW'(H - 1);
  localparam logic [YW-1:0] OYM_S2 = YW'((H + 1) / 2 - 1);

  localparam logic signed [XI-1:0] HALF_KX = XI'(K / 2);
  localparam logic signed [YI-1:0] HALF_KY = YI'(K / 2);
  localparam logic signed [XI-1:0] W_LIM   = XI'(W);
  localparam logic signed [YI-1:0] H_LIM   = YI'(H);

  state_e state_q, state_d;
  logic   same_q, same_d;
  logic   stride2_q, stride2_d;
  logic   done_q, done_d;

  logic [ICW-1:0] ich_cnt;
  logic [KW-1:0]  kx_cnt, ky_cnt;
  logic [GW-1:0]  grp_cnt;
  logic [XW-1:0]  ox_cnt, ox_max;
  logic [YW-1:0]  oy_cnt, oy_max;
  logic ich_wrap, kx_wrap, ky_wrap, grp_wrap, ox_wrap, oy_wrap;

  logic run_st, out_st, out_accept, pad_c;
  logic [XI-1:0] ox_scaled;
  logic [YI-1:0] oy_scaled;
  logic signed [XI-1:0] in_x_w;
  logic signed [YI-1:0] in_y_w;

  assign run_st     = (state_q == ST_RUN);
  assign out_st     = (state_q == ST_OUT);
  assign out_accept = out_st && output_ready;

  assign ox_max = same_q ? (stride2_q ? OXM_S2 : OXM_S1) : (stride2_q ? OXM_V2 : OXM_V1);
  assign oy_max = same_q ? (stride2_q ? OYM_S2 : OYM_S1) : (stride2_q ? OYM_V2 : OYM_V1);

  // Inner counters wrap to zero on the group's last step; outer ones move on output accept.
  wrap_counter #(.WIDTH(ICW)) u_ich (.clk(clk), .rst_n(arst_n_in), .inc(step_fire),
    .max(ICW'(INPUT_NB_CHANNELS - 1)), .count(ich_cnt), .wrap(ich_wrap));
  wrap_counter #(.WIDTH(KW)) u_kx (.clk(clk), .rst_n(arst_n_in), .inc(ich_wrap),
    .max(KW'(K - 1)), .count(kx_cnt), .wrap(kx_wrap));
  wrap_counter #(.WIDTH(KW)) u_ky (.clk(clk), .rst_n(arst_n_in), .inc(kx_wrap),
    .max(KW'(K - 1)), .count(ky_cnt), .wrap(ky_wrap));
  wrap_counter #(.WIDTH(GW)) u_grp (.clk(clk), .rst_n(arst_n_in), .inc(out_accept),
    .max(GW'(NG - 1)), .count(grp_cnt), .wrap(grp_wrap));
  wrap_counter #(.WIDTH(XW)) u_ox (.clk(clk), .rst_n(arst_n_in), .inc(grp_wrap),
    .max(ox_max), .count(ox_cnt), .wrap(ox_wrap));
  wrap_counter #(.WIDTH(YW)) u_oy (.clk(clk), .rst_n(arst_n_in), .inc(ox_wrap),
    .max(oy_max), .count(oy_cnt), .wrap(oy_wrap));

  // Input coordinate computed wide so the pad test never sees a wrapped value.
  assign ox_scaled = stride2_q ? (XI'(ox_cnt) << 1) : XI'(ox_cnt);
  assign oy_scaled = stride2_q ? (YI'(oy_cnt) << 1) : YI'(oy_cnt);
  assign in_x_w = $signed(ox_scaled) + $signed(XI'(kx_cnt)) - (same_q ? HALF_KX : '0);
  assign in_y_w = $signed(oy_scaled) + $signed(YI'(ky_cnt)) - (same_q ? HALF_KY : '0);
  assign pad_c  = in_x_w[XI-1] || (in_x_w >= W_LIM) || in_y_w[YI-1] || (in_y_w >= H_LIM);

  assign in_x      = in_x_w[CXW-1:0];
  assign in_y      = in_y_w[CYW-1:0];
  assign ich       = ich_cnt;
  assign kx        = kx_cnt;
  assign ky        = ky_cnt;
  assign och_base  = OBW'(32'(grp_cnt) * OC_PARALLEL);
  assign pad_zero  = run_st && pad_c;
  assign con_ready = run_st && !pad_c;
  assign step_fire = run_st && (pad_c || con_valid);
  assign acc_first = run_st && (ky_cnt == '0) && (kx_cnt == '0) && (ich_cnt == '0);
  assign acc_last  = run_st && (ky_cnt == KW'(K - 1)) && (kx_cnt == KW'(K - 1))
                     && (ich_cnt == ICW'(INPUT_NB_CHANNELS - 1));

  assign output_valid = out_st;
  assign output_x     = ox_cnt;
  assign output_y     = oy_cnt;
  assign output_ch    = och_base;
  assign running      = (state_q != ST_IDLE);
  assign done         = done_q;

  always_comb begin
    state_d   = state_q;
    same_d    = same_q;
    stride2_d = stride2_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          same_d    = cfg_same_pad;
          stride2_d = cfg_stride2;
        end
      end
      ST_RUN: begin
        if (step_fire && acc_last) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (output_ready) begin
          if (oy_wrap) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      state_q   <= ST_IDLE;
      same_q    <= 1'b0;
      stride2_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      same_q    <= same_d;
      stride2_q <= stride2_d;
      done_q    <= done_d;
    end
  end

endmodule
